// File: rtl/key_pkg.sv
// Shared types and timing defaults for the key trigger front end.
// The counter width is derived from the longest of the three timing windows.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_DEB   = 2'd1,
        HELD        = 2'd2,
        RELEASE_DEB = 2'd3
    } key_state_e;

    // Defaults for a 50 MHz clock: 20 ms debounce, 1 s long press, 200 ms repeat.
    localparam int DEF_DEB_CYC  = 1000000;
    localparam int DEF_LONG_CYC = 50000000;
    localparam int DEF_REP_CYC  = 10000000;

    function automatic int cnt_width(input int deb_cyc, input int long_cyc, input int rep_cyc);
        int max_cyc;
        max_cyc = deb_cyc;
        if (long_cyc > max_cyc) max_cyc = long_cyc;
        if (rep_cyc > max_cyc) max_cyc = rep_cyc;
        return $clog2(max_cyc) + 1;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous level inputs.
// RST_VAL lets each user pick the inactive level seen during and after reset.
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/key_trig_gen.sv
// Debounced key front end: one-cycle trigger on press, release and long-press pulses,
// and optional auto-repeat triggers while the key stays held after a long press.
module key_trig_gen
    import key_pkg::*;
#(
    parameter int   DEB_CYC    = DEF_DEB_CYC,
    parameter int   LONG_CYC   = DEF_LONG_CYC,
    parameter int   REP_CYC    = DEF_REP_CYC,
    parameter logic KEY_ACTIVE = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic key_in,
    input  logic rep_en,
    output logic trig_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic key_level
);

    localparam int CNT_W = cnt_width(DEB_CYC, LONG_CYC, REP_CYC);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYC - 1);

    logic key_s2;
    logic pressed;

    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             long_flag_q, long_flag_d;
    logic             trig_q, trig_d;
    logic             rel_q, rel_d;
    logic             long_q, long_d;
    logic             level_q, level_d;

    sync2 #(.RST_VAL(~KEY_ACTIVE)) u_key_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (key_in),
        .q    (key_s2)
    );

    assign pressed = (key_s2 == KEY_ACTIVE);

    always_comb begin
        state_d     = state_q;
        deb_cnt_d   = deb_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        rep_cnt_d   = rep_cnt_q;
        long_flag_d = long_flag_q;
        level_d     = level_q;
        trig_d      = 1'b0;
        rel_d       = 1'b0;
        long_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (pressed) begin
                    state_d   = PRESS_DEB;
                    deb_cnt_d = '0;
                end
            end
            PRESS_DEB: begin
                if (!pressed) begin
                    state_d = IDLE;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d     = HELD;
                    trig_d      = 1'b1;
                    level_d     = 1'b1;
                    hold_cnt_d  = '0;
                    rep_cnt_d   = '0;
                    long_flag_d = 1'b0;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            HELD: begin
                // hold_cnt/rep_cnt are left untouched on exit so a short release glitch resumes timing.
                if (!pressed) begin
                    state_d   = RELEASE_DEB;
                    deb_cnt_d = '0;
                end else if (!long_flag_q) begin
                    if (hold_cnt_q == LONG_LAST) begin
                        long_d      = 1'b1;
                        long_flag_d = 1'b1;
                        rep_cnt_d   = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end else if (rep_en) begin
                    if (rep_cnt_q == REP_LAST) begin
                        trig_d    = 1'b1;
                        rep_cnt_d = '0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + 1'b1;
                    end
                end else begin
                    rep_cnt_d = '0;
                end
            end
            RELEASE_DEB: begin
                if (pressed) begin
                    state_d = HELD;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d     = IDLE;
                    rel_d       = 1'b1;
                    level_d     = 1'b0;
                    long_flag_d = 1'b0;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            deb_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            rep_cnt_q   <= '0;
            long_flag_q <= 1'b0;
            trig_q      <= 1'b0;
            rel_q       <= 1'b0;
            long_q      <= 1'b0;
            level_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            deb_cnt_q   <= deb_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            long_flag_q <= long_flag_d;
            trig_q      <= trig_d;
            rel_q       <= rel_d;
            long_q      <= long_d;
            level_q     <= level_d;
        end
    end

    assign trig_pulse    = trig_q;
    assign release_pulse = rel_q;
    assign long_pulse    = long_q;
    assign key_level     = level_q;

endmodule

// File: doc/key_trig_gen.md
Name: key_trig_gen

Overview:
Upstream trigger stage for the 10-cycle pulse generator. It takes a raw mechanical key input, synchronises and debounces it, and produces a one-cycle trig_pulse that drives the generator's en input. It also provides press level, release pulse, long-press detection and optional auto-repeat triggers while the key is held.

Parameters:
- DEB_CYC, 1000000, debounce window in clk cycles (20 ms at 50 MHz); must be >= 2.
- LONG_CYC, 50000000, hold time in HELD before long_pulse fires (1 s).
- REP_CYC, 10000000, auto-repeat period after a long press (200 ms).
- KEY_ACTIVE, 1'b0, key_in level meaning "pressed".
- CNT_W, $clog2 of max(DEB_CYC, LONG_CYC, REP_CYC) plus 1, shared counter width (derived, not overridden).

Ports:
- clk, input, 1, system clock.
- rstn, input, 1, reset, asynchronous, active-low.
- key_in, input, 1, raw asynchronous key level.
- rep_en, input, 1, enables auto-repeat triggers; sampled every cycle.
- trig_pulse, output, 1, one-cycle trigger pulse for downstream en.
- release_pulse, output, 1, one cycle on debounced release.
- long_pulse, output, 1, one cycle when a long press is reached.
- key_level, output, 1, debounced pressed level (1 = pressed).

Behaviour:
- All outputs are registered; all reset to 0. Internal state resets to IDLE, counters to 0, and both synchroniser flops to ~KEY_ACTIVE.
- Synchroniser: key_in passes through 2 flops to give s2. pressed = (s2 == KEY_ACTIVE).
- FSM states: IDLE, PRESS_DEB, HELD, RELEASE_DEB.
- IDLE:
  - pressed -> PRESS_DEB, deb_cnt = 0.
- PRESS_DEB:
  - !pressed -> IDLE (bounce rejected, no output).
  - deb_cnt == DEB_CYC-1 -> HELD; trig_pulse = 1 and key_level = 1 on the same edge; hold_cnt = 0, rep_cnt = 0, long_flag = 0.
  - otherwise deb_cnt + 1.
- HELD:
  - !pressed -> RELEASE_DEB, deb_cnt = 0. hold_cnt and rep_cnt freeze.
  - else if !long_flag: hold_cnt + 1. When hold_cnt == LONG_CYC-1: long_pulse = 1, long_flag = 1, rep_cnt = 0.
  - else if long_flag and rep_en: rep_cnt + 1. When rep_cnt == REP_CYC-1: trig_pulse = 1, rep_cnt = 0.
  - rep_en = 0 holds rep_cnt at 0.
- RELEASE_DEB:
  - pressed -> HELD; frozen counters resume (a release glitch does not restart long-press timing).
  - deb_cnt == DEB_CYC-1 -> IDLE; release_pulse = 1, key_level = 0; long_flag cleared.
  - otherwise deb_cnt + 1.
- Latency: key_in stable-active before edge 1 gives pressed visible after edge 2 and PRESS_DEB entered at edge 3. trig_pulse is high in the cycle after edge DEB_CYC+3, for exactly 1 cycle. Release latency is the same, DEB_CYC+3.
- Pulse outputs default to 0 every cycle; they are never high for 2 consecutive cycles.
- trig_pulse and long_pulse never coincide. The first repeat trigger occurs REP_CYC cycles after long_pulse.
- Async rstn mid-operation returns to IDLE immediately with all outputs 0. After release, a held key is treated as a new press: full debounce, then trig_pulse.
- Counters saturate by construction and never wrap: each compare resets or exits before overflow.

Decomposition:
- Package key_pkg holds:
  - the state enum (IDLE=2'd0, PRESS_DEB=2'd1, HELD=2'd2, RELEASE_DEB=2'd3);
  - the CNT_W helper function;
  - default timing constants for 50 MHz.
- One natural sub-module, sync2: a 2-flop synchroniser with a reset-value parameter. It is reused by other asynchronous inputs in the design.
- The FSM, counters and output registers stay in key_trig_gen.

Test Plan:
All scenarios use DEB_CYC=4, LONG_CYC=20, REP_CYC=8, KEY_ACTIVE=0.
- Clean press: key_in drops to 0 and holds -> trig_pulse high for 1 cycle after edge 7, key_level=1 from the same edge, no other pulses for 19 cycles.
- Bounce: key_in low for 3 cycles, high for 2, then low stable -> no trig_pulse from the glitch; a single trig_pulse 7 edges after the final stable low.
- Long press with rep_en=1: hold 60 cycles -> trig at edge 7, long_pulse about 20 cycles later, then trig_pulse every 8 cycles (4 repeats); release -> release_pulse 7 edges after key_in rises, key_level=0.
- Long press with rep_en=0 -> exactly one trig_pulse and one long_pulse, no repeats; toggling rep_en to 1 mid-hold -> first repeat 8 cycles later.
- Release glitch in HELD: key_in high for 2 cycles at hold_cnt=10 -> returns to HELD with no release_pulse; long_pulse fires at the original cumulative hold count.
- Reset mid-hold: assert rstn=0 in HELD -> all outputs 0 within the same cycle; after deassertion with key still pressed, trig_pulse again after DEB_CYC+3 edges.
